song_recorder: RTL

//  Records live keyboard notes into an internal song memory in the layout the song players consume:

---
 rtl/song_recorder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/song_recorder.sv
// song_recorder: debounces live key notes and records them as {note,duration} words behind a
// count word. Build option RECORDER_RESTS_EN additionally stores long silences as rest entries.
module song_recorder #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int DUR_W     = 32,
  parameter int DEB_TICKS = 1000000,
  parameter int REST_MIN  = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_rec_en,
  input  logic [9:0]          i_note_in,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [10+DUR_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0]   o_length,
  output logic                o_recording,
  output logic                o_full,
  output logic                o_done
);

  localparam int ENT_W = 10 + DUR_W;
  localparam int DEB_W = $clog2(DEB_TICKS + 1);
  localparam int MEM_N = 2 ** ADDR_W;

`ifdef RECORDER_RESTS_EN
  localparam bit REST_EN = 1'b1;
`else
  localparam bit REST_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [9:0]        r_sync1, r_sync2, r_cand, r_cur, r_note;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [DEB_W-1:0]  w_deb_next;
  logic [2:0]        r_state, w_state_nxt;
  logic [DUR_W-1:0]  r_dur, w_dur_inc;
  logic [ADDR_W-1:0] r_length, r_wr_ptr;
  logic              r_rec_d;
  logic              w_commit, w_capture, w_last, w_rest_long, w_start;
  logic [ENT_W-1:0]  w_commit_data;
  logic [ENT_W-1:0]  r_mem [MEM_N];
  logic [ENT_W-1:0]  r_rd_data;

  // Input path: 2-flop sync, then a value is accepted after DEB_TICKS stable cycles.
  // The delay is identical for key press and release, so durations are not skewed.
  assign w_deb_next = (r_sync2 == r_cand) ? r_deb_cnt + 1'b1 : DEB_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_cand    <= '0;
      r_cur     <= '0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= i_note_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_cur) begin
        r_cand    <= r_cur;
        r_deb_cnt <= '0;
      end else if (w_deb_next >= DEB_W'(DEB_TICKS)) begin
        r_cur     <= r_sync2;
        r_cand    <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_cand    <= r_sync2;
        r_deb_cnt <= w_deb_next;
      end
    end
  end

  // Committed duration counts the commit cycle itself, so it equals the cycles cur was held.
  assign w_dur_inc   = (&r_dur) ? r_dur : r_dur + 1'b1;
  assign w_rest_long = (64'(w_dur_inc) >= 64'(REST_MIN));
  assign w_last      = (r_length == ADDR_W'(DEPTH - 2));
  assign w_start     = (r_state == S_IDLE) && i_rec_en && !r_rec_d;

  always_comb begin
    w_state_nxt   = r_state;
    w_commit      = 1'b0;
    w_capture     = 1'b0;
    w_commit_data = '0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_ARMED;
      S_ARMED: begin
        if (!i_rec_en) w_state_nxt = S_DONE;
        else if (r_cur != 10'd0) begin
          w_state_nxt = S_CAPTURE;
          w_capture   = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (!i_rec_en) begin
          w_commit      = 1'b1;
          w_commit_data = {r_note, w_dur_inc};
          w_state_nxt   = S_DONE;
        end else if (r_cur != r_note) begin
          w_commit      = 1'b1;
          w_commit_data = {r_note, w_dur_inc};
          if (w_last) w_state_nxt = S_DONE;
          else if (r_cur != 10'd0) begin
            w_state_nxt = S_CAPTURE;
            w_capture   = 1'b1;
          end else w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (!i_rec_en) w_state_nxt = S_DONE;
        else if (r_cur != 10'd0) begin
          if (REST_EN && w_rest_long) begin
            w_commit      = 1'b1;
            w_commit_data = {10'd0, w_dur_inc};
          end
          if (w_commit && w_last) w_state_nxt = S_DONE;
          else begin
            w_state_nxt = S_CAPTURE;
            w_capture   = 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rec_d  <= 1'b0;
      r_length <= '0;
      r_wr_ptr <= ADDR_W'(1);
    end else begin
      r_state <= w_state_nxt;
      r_rec_d <= i_rec_en;
      if (w_start) begin
        r_length <= '0;
        r_wr_ptr <= ADDR_W'(1);
      end else if (w_commit) begin
        r_length <= r_length + 1'b1;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Datapath: note/duration tracking and the song memory carry no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_note <= r_cur;
      r_dur  <= '0;
    end else if (w_commit || w_start) begin
      r_dur <= '0;
    end else begin
      r_dur <= w_dur_inc;
    end
    if (w_commit) r_mem[r_wr_ptr] <= w_commit_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else if (i_rd_addr == '0) r_rd_data <= ENT_W'(r_length);
    else if ({1'b0, i_rd_addr} >= (ADDR_W + 1)'(DEPTH)) r_rd_data <= '0;
    else r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data   = r_rd_data;
  assign o_length    = r_length;
  assign o_full      = (r_length == ADDR_W'(DEPTH - 1));
  assign o_done      = (r_state == S_DONE);
  assign o_recording = (r_state == S_ARMED) || (r_state == S_CAPTURE) || (r_state == S_GAP);

endmodule
